// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg: shared core types, limits and helpers for the issue/writeback stages.
package hsv_core_pkg;

    typedef logic [4:0]  reg_addr;
    typedef logic [31:0] word;

    localparam int WB_PORTS_MAX = 8;

    typedef struct packed {
        reg_addr addr;
        word     data;
    } wb_req_t;

    function automatic int wrap_idx(int base, int off, int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/hsv_core_rr_arbiter.sv
// hsv_core_rr_arbiter: round-robin arbiter with one-hot grant, owning the rotating priority pointer.
module hsv_core_rr_arbiter
    import hsv_core_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk_core,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_en,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IW-1:0]        o_idx,
    output logic                 o_hit
);

    logic [IW-1:0] r_ptr;

    // Search starts at the pointer and wraps, so the last winner gets lowest priority.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_hit   = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (i_en && !o_hit && i_req[wrap_idx(int'(r_ptr), k, NUM_PORTS)]) begin
                o_hit = 1'b1;
                o_grant[wrap_idx(int'(r_ptr), k, NUM_PORTS)] = 1'b1;
                o_idx = IW'(wrap_idx(int'(r_ptr), k, NUM_PORTS));
            end
        end
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (o_hit)
            r_ptr <= IW'(wrap_idx(int'(o_idx), 1, NUM_PORTS));
    end

endmodule

// File: rtl/hsv_core_issue_wb_arbiter.sv
// hsv_core_issue_wb_arbiter: shares the regfile write port among writeback units;
// the registered write doubles as the issue-stage bypass source.
module hsv_core_issue_wb_arbiter
    import hsv_core_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    clk_core,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    req_valid,
    output logic [NUM_PORTS-1:0]    req_ready,
    input  reg_addr [NUM_PORTS-1:0] req_addr,
    input  word [NUM_PORTS-1:0]     req_data,
    input  logic                    flush,
    output logic                    wr_en,
    output reg_addr                 wr_addr,
    output word                     wr_data,
    output logic [IW-1:0]           grant_idx
);

    logic          w_arb_en;
    logic          w_hit;
    logic [IW-1:0] w_idx;
    wb_req_t       w_sel;
    wb_req_t       r_wr;
    logic          r_en;
    logic [IW-1:0] r_idx;

    assign w_arb_en = ~(flush | rst);
    assign w_sel    = {req_addr[w_idx], req_data[w_idx]};

    hsv_core_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .clk_core (clk_core),
        .rst      (rst),
        .i_req    (req_valid),
        .i_en     (w_arb_en),
        .o_grant  (req_ready),
        .o_idx    (w_idx),
        .o_hit    (w_hit)
    );

    // x0 grants still advance the pointer and refresh the bypass fields, but never write.
    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            r_en  <= 1'b0;
            r_wr  <= '0;
            r_idx <= '0;
        end else begin
            r_en <= w_hit && (w_sel.addr != '0);
            if (w_hit) begin
                r_wr  <= w_sel;
                r_idx <= w_idx;
            end
        end
    end

    assign wr_en     = r_en;
    assign wr_addr   = r_wr.addr;
    assign wr_data   = r_wr.data;
    assign grant_idx = r_idx;

endmodule

// File: tb/tb_hsv_core_issue_wb_arbiter.sv
// tb_hsv_core_issue_wb_arbiter: directed stimulus with a behavioural round-robin writeback model.
module tb_hsv_core_issue_wb_arbiter;

    localparam int N = 4;

    logic                 clk_core;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][4:0]    req_addr;
    logic [N-1:0][31:0]   req_data;
    logic                 flush;
    logic                 wr_en;
    logic [4:0]           wr_addr;
    logic [31:0]          wr_data;
    logic [1:0]           grant_idx;

    int n_chk = 0;
    int n_err = 0;

    int          m_ptr  = 0;
    logic        m_en   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_idx  = 0;

    hsv_core_issue_wb_arbiter #(.NUM_PORTS(N)) dut (
        .clk_core  (clk_core),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_idx (grant_idx)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    // Model: the write port goes to the first valid requester at or after the pointer.
    always @(posedge rst) begin
        m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_idx = 0;
    end

    always @(posedge clk_core) begin
        int w;
        int p;
        if (!rst) begin
            w = -1;
            if (!flush)
                for (int k = 0; k < N; k++) begin
                    p = (m_ptr + k) % N;
                    if (w < 0 && req_valid[p]) w = p;
                end
            m_en = (w >= 0) && (req_addr[w] != 5'd0);
            if (w >= 0) begin
                m_addr = req_addr[w];
                m_data = req_data[w];
                m_idx  = w;
                m_ptr  = (w + 1) % N;
            end
        end
    end

    always @(negedge clk_core) begin
        logic [N-1:0] er;
        int p;
        er = '0;
        if (!rst && !flush)
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (er == '0 && req_valid[p]) er[p] = 1'b1;
            end
        chk("m_ready", 64'(req_ready), 64'(er));
        chk("m_wr_en", 64'(wr_en), 64'(m_en));
        chk("m_wr_addr", 64'(wr_addr), 64'(m_addr));
        chk("m_wr_data", 64'(wr_data), 64'(m_data));
        chk("m_grant_idx", 64'(grant_idx), 64'(m_idx));
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        flush = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int w;
        rst = 1'b1;
        flush = 1'b0;
        req_valid = 4'b1111;
        req_addr = '0;
        req_data = '0;
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        req_valid = '0;
        rst = 1'b0;

        // single write
        tick();
        req_addr[0] = 5'd3; req_data[0] = 32'hdeadbeef; req_valid = 4'b0001;
        #1 chk("t1_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        chk("t1_wr_en", 64'(wr_en), 64'd1);
        chk("t1_wr_addr", 64'(wr_addr), 64'd3);
        chk("t1_wr_data", 64'(wr_data), 64'hdeadbeef);
        chk("t1_grant_idx", 64'(grant_idx), 64'd0);
        tick();
        chk("t1_wr_en_drop", 64'(wr_en), 64'd0);

        // all four valid: rotate 0..3 with back-to-back writes
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_addr[i] = 5'(i + 1);
            req_data[i] = 32'(32'h11 * (i + 1));
        end
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            #1 chk("t2_ready", 64'(req_ready), 64'(1 << i));
            tick();
            chk("t2_wr_en", 64'(wr_en), 64'd1);
            chk("t2_wr_addr", 64'(wr_addr), 64'(i + 1));
        end
        req_valid = 4'b1001;
        #1 chk("t2_ptr_wrapped", 64'(req_ready), 64'b0001);
        tick();

        // x0 write: granted, pointer moves, no regfile write
        req_addr[1] = 5'd0; req_data[1] = 32'hcafebabe; req_valid = 4'b0010;
        #1 chk("t3_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b0110;
        chk("t3_wr_en", 64'(wr_en), 64'd0);
        chk("t3_grant_idx", 64'(grant_idx), 64'd1);
        chk("t3_wr_data", 64'(wr_data), 64'hcafebabe);
        #1 chk("t3_ptr_is_2", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;

        // flush blocks grants; pending requests survive
        do_reset();
        req_addr[1] = 5'd2;
        req_valid = 4'b0101; flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("t4_flush_ready", 64'(req_ready), 64'd0);
            tick();
            chk("t4_flush_wr_en", 64'(wr_en), 64'd0);
        end
        flush = 1'b0;
        #1 chk("t4_first", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0100;
        chk("t4_first_idx", 64'(grant_idx), 64'd0);
        #1 chk("t4_second", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b0001;
        chk("t4_second_idx", 64'(grant_idx), 64'd2);
        tick();
        flush = 1'b1; req_valid = 4'b0010;
        #1 chk("t4_inflight_wr_en", 64'(wr_en), 64'd1);
        chk("t4_inflight_ready", 64'(req_ready), 64'd0);
        tick();
        chk("t4_after_flush_wr_en", 64'(wr_en), 64'd0);
        flush = 1'b0; req_valid = '0;

        // async reset mid-cycle drops the accepted write
        tick();
        req_valid = 4'b1000;
        #1 chk("t5_grant3", 64'(req_ready), 64'b1000);
        tick();
        req_valid = 4'b0100;
        chk("t5_wr_idx3", 64'(grant_idx), 64'd3);
        chk("t5_wr_en_pre", 64'(wr_en), 64'd1);
        #2 rst = 1'b1;
        #1 chk("t5_async_wr_en", 64'(wr_en), 64'd0);
        chk("t5_async_idx", 64'(grant_idx), 64'd0);
        chk("t5_async_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        req_addr[0] = 5'd15; req_data[0] = 32'h12345678; req_valid = 4'b1001;
        #1 chk("t5_restart", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        chk("t5_wr_en", 64'(wr_en), 64'd1);
        chk("t5_wr_addr", 64'(wr_addr), 64'd15);
        chk("t5_wr_data", 64'(wr_data), 64'h12345678);

        // starvation: 0 always valid, 2 joins and must be served within N cycles
        req_valid = 4'b0001;
        tick();
        tick();
        req_valid = 4'b0101;
        for (int r = 0; r < 4; r++) begin
            w = 0;
            #1;
            while (!req_ready[2] && w < N) begin
                tick();
                w++;
            end
            chk("t6_wait_bound", 64'(w < N), 64'd1);
            tick();
        end
        req_valid = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
